// File: rtl/cpu_mem_pkg.sv
// ----------------------------------------------------------------------------
// cpu_mem_pkg
// Shared definitions for the CPU data-memory path.
//   - SZ_B / SZ_H / SZ_W / SZ_RSV : req_size encodings (reserved behaves as word)
//   - dmem_state_e                 : access-unit FSM states
//   - is_subword()                 : true for byte/half sizes (these need a merge)
// ----------------------------------------------------------------------------
package cpu_mem_pkg;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } dmem_state_e;

    function automatic logic is_subword(input logic [1:0] size);
        return (size == SZ_B) || (size == SZ_H);
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// ----------------------------------------------------------------------------
// dmem_lane_unit
// Purely combinational little-endian lane logic.
//   Extract path : ext_word/ext_lane/ext_size/ext_unsigned -> ext_data
//                  (byte or half selected and sign/zero extended; word and
//                  reserved sizes pass the word through unchanged)
//   Merge path   : mrg_old/mrg_lane/mrg_size/mrg_wdata -> mrg_word
//                  (old word with the addressed byte or half replaced)
// Half accesses use lane[1] only, so lane[0] is ignored for halves.
// ----------------------------------------------------------------------------
module dmem_lane_unit
    import cpu_mem_pkg::*;
(
    input  logic [31:0] ext_word,
    input  logic [1:0]  ext_lane,
    input  logic [1:0]  ext_size,
    input  logic        ext_unsigned,
    output logic [31:0] ext_data,
    input  logic [31:0] mrg_old,
    input  logic [1:0]  mrg_lane,
    input  logic [1:0]  mrg_size,
    input  logic [15:0] mrg_wdata,
    output logic [31:0] mrg_word
);

    logic [7:0]  ext_byte;
    logic [15:0] ext_half;

    always_comb begin
        ext_byte = ext_word[7:0];
        case (ext_lane)
            2'd0:    ext_byte = ext_word[7:0];
            2'd1:    ext_byte = ext_word[15:8];
            2'd2:    ext_byte = ext_word[23:16];
            default: ext_byte = ext_word[31:24];
        endcase
        ext_half = ext_lane[1] ? ext_word[31:16] : ext_word[15:0];
    end

    always_comb begin
        ext_data = ext_word;
        case (ext_size)
            SZ_B:    ext_data = {{24{~ext_unsigned & ext_byte[7]}}, ext_byte};
            SZ_H:    ext_data = {{16{~ext_unsigned & ext_half[15]}}, ext_half};
            default: ext_data = ext_word;
        endcase
    end

    // Each output byte independently decides whether it is the store target.
    // For halves, the byte at odd position within the half takes wdata[15:8].
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            localparam logic [1:0] LANE = 2'(gi);
            logic hit_b;
            logic hit_h;
            assign hit_b = (mrg_size == SZ_B) && (mrg_lane == LANE);
            assign hit_h = (mrg_size == SZ_H) && (mrg_lane[1] == LANE[1]);
            assign mrg_word[8*gi +: 8] = hit_b ? mrg_wdata[7:0] :
                                         hit_h ? mrg_wdata[8*(gi%2) +: 8] :
                                                 mrg_old[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/dmem_access_unit.sv
// ----------------------------------------------------------------------------
// dmem_access_unit
// Bridges the MEM stage to a word-wide SRAM (async read, sync write).
// Loads complete combinationally; word stores write in the request cycle;
// byte/half stores capture the old word and finish one cycle later (MERGE).
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/we/size/unsigned/addr/wdata : MEM-stage request
//   req_ready           : access completes this cycle
//   rsp_rdata           : load data (valid with req_valid & req_ready & !req_we)
//   misalign            : misaligned access flagged (only with trap option)
//   mem_a/mem_d/mem_we  : SRAM word address, write data, write enable
//   mem_rdata           : SRAM async read data at mem_a
//
// Build option
//   DMEM_MISALIGN_TRAP_EN : when defined, misaligned half/word accesses
//                           complete immediately with misalign=1 and no
//                           write; when undefined, low address bits below the
//                           access size are ignored and misalign stays 0.
// ----------------------------------------------------------------------------
module dmem_access_unit
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic [31:0]       rsp_rdata,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_d,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);

    dmem_state_e       state_reg, state_next;
    logic [31:0]       old_word_reg, old_word_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [1:0]        lane_reg, lane_next;
    logic [1:0]        size_reg, size_next;
    logic [15:0]       wdata_reg, wdata_next;

    logic [31:0]       ext_data;
    logic [31:0]       merged_word;
    logic              misaligned_req;

    // Byte-offset bits above the word index are not part of the SRAM address.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, req_addr[31:ADDR_W+2]};

`ifdef DMEM_MISALIGN_TRAP_EN
    always_comb begin
        misaligned_req = 1'b0;
        case (req_size)
            SZ_B:    misaligned_req = 1'b0;
            SZ_H:    misaligned_req = req_addr[0];
            default: misaligned_req = (req_addr[1:0] != 2'b00);
        endcase
    end
`else
    assign misaligned_req = 1'b0;
`endif

    // Load extraction works on the live request; the merge works only on
    // the values captured when the sub-word store was accepted, so the SRAM
    // read never feeds the SRAM write data in the same cycle.
    dmem_lane_unit u_lane (
        .ext_word     (mem_rdata),
        .ext_lane     (req_addr[1:0]),
        .ext_size     (req_size),
        .ext_unsigned (req_unsigned),
        .ext_data     (ext_data),
        .mrg_old      (old_word_reg),
        .mrg_lane     (lane_reg),
        .mrg_size     (size_reg),
        .mrg_wdata    (wdata_reg),
        .mrg_word     (merged_word)
    );

    always_comb begin
        state_next    = state_reg;
        old_word_next = old_word_reg;
        addr_next     = addr_reg;
        lane_next     = lane_reg;
        size_next     = size_reg;
        wdata_next    = wdata_reg;
        req_ready     = 1'b0;
        rsp_rdata     = 32'd0;
        misalign      = 1'b0;
        mem_a         = req_addr[ADDR_W+1:2];
        mem_d         = req_wdata;
        mem_we        = 1'b0;

        // Everything stays quiet while reset is held; this also drops the
        // write of a merge interrupted by reset.
        if (!reset) begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (misaligned_req) begin
                            req_ready = 1'b1;
                            misalign  = 1'b1;
                        end else if (!req_we) begin
                            req_ready = 1'b1;
                            rsp_rdata = ext_data;
                        end else if (!is_subword(req_size)) begin
                            req_ready = 1'b1;
                            mem_we    = 1'b1;
                        end else begin
                            old_word_next = mem_rdata;
                            addr_next     = req_addr[ADDR_W+1:2];
                            lane_next     = req_addr[1:0];
                            size_next     = req_size;
                            wdata_next    = req_wdata[15:0];
                            state_next    = ST_MERGE;
                        end
                    end
                end
                ST_MERGE: begin
                    mem_a      = addr_reg;
                    mem_d      = merged_word;
                    mem_we     = 1'b1;
                    req_ready  = 1'b1;
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            old_word_reg <= 32'd0;
            addr_reg     <= '0;
            lane_reg     <= 2'd0;
            size_reg     <= 2'd0;
            wdata_reg    <= 16'd0;
        end else begin
            state_reg    <= state_next;
            old_word_reg <= old_word_next;
            addr_reg     <= addr_next;
            lane_reg     <= lane_next;
            size_reg     <= size_next;
            wdata_reg    <= wdata_next;
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
module tb_dmem_access_unit;

    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              req_ready;
    logic [31:0]       rsp_rdata;
    logic              misalign;
    logic [ADDR_W-1:0] mem_a;
    logic [31:0]       mem_d;
    logic              mem_we;
    logic [31:0]       mem_rdata;

    logic [31:0] sram [0:(1<<ADDR_W)-1];
    logic [31:0] w0_exp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_rdata = sram[mem_a];
    always @(posedge clk) if (mem_we) sram[mem_a] <= mem_d;

    dmem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_rdata    (rsp_rdata),
        .misalign     (misalign),
        .mem_a        (mem_a),
        .mem_d        (mem_d),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata)
    );

    // Drive a request just after the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic v, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid = v; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = d;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h0, 32'h11);
        $display("reset cycle store: ready=%0b we=%0b mis=%0b", req_ready, mem_we, misalign);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %0b want 0", req_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %0b want 0", mem_we); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign got %0b want 0", misalign); end
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %08h want 00000000", rsp_rdata); end
        reset = 1'b0;
    endtask

    task automatic test_idle();
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h12345678);
        $display("idle: ready=%0b we=%0b rdata=%08h", req_ready, mem_we, rsp_rdata);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %0b want 0", req_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL idle_we got %0b want 0", mem_we); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL idle_rdata got %08h want 00000000", rsp_rdata); end
    endtask

    task automatic test_load();
        logic [1:0]  sz [6]  = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11};
        logic        un [6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] ad [6]  = '{32'h1, 32'h2, 32'h0, 32'h3, 32'h0, 32'h0};
        logic [31:0] ex [6]  = '{32'hFFFFFFAA, 32'h00008899, 32'hFFFFAABB,
                                 32'h00000088, 32'h8899AABB, 32'h8899AABB};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, sz[i], un[i], ad[i], 32'h0);
            $display("load size=%0d uns=%0b addr=%08h ready=%0b rdata=%08h", sz[i], un[i], ad[i], req_ready, rsp_rdata);
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ld%0d_ready got %0b want 1", i, req_ready); end
            checks++; if (rsp_rdata !== ex[i]) begin errors++; $display("FAIL ld%0d_rdata got %08h want %08h", i, rsp_rdata, ex[i]); end
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL ld%0d_we got %0b want 0", i, mem_we); end
        end
    endtask

    task automatic test_byte_store();
        drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h3, 32'h1234565A);
        $display("sb cycle1: ready=%0b we=%0b", req_ready, mem_we);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL sb_c1_ready got %0b want 0", req_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL sb_c1_we got %0b want 0", mem_we); end
        drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h3, 32'h1234565A);
        $display("sb cycle2: ready=%0b we=%0b a=%0d d=%08h", req_ready, mem_we, mem_a, mem_d);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL sb_c2_ready got %0b want 1", req_ready); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL sb_c2_we got %0b want 1", mem_we); end
        checks++; if (mem_d !== 32'h5A99AABB) begin errors++; $display("FAIL sb_c2_d got %08h want 5A99AABB", mem_d); end
        checks++; if (mem_a !== 11'd0) begin errors++; $display("FAIL sb_c2_a got %0d want 0", mem_a); end
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        $display("lw after sb: ready=%0b rdata=%08h", req_ready, rsp_rdata);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %0b want 1", req_ready); end
        checks++; if (rsp_rdata !== 32'h5A99AABB) begin errors++; $display("FAIL b2b_rdata got %08h want 5A99AABB", rsp_rdata); end
    endtask

    task automatic test_word_store();
        drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h4, 32'hDEADBEEF);
        $display("sw: ready=%0b we=%0b a=%0d d=%08h", req_ready, mem_we, mem_a, mem_d);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL sw_ready got %0b want 1", req_ready); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL sw_we got %0b want 1", mem_we); end
        checks++; if (mem_a !== 11'd1) begin errors++; $display("FAIL sw_a got %0d want 1", mem_a); end
        checks++; if (mem_d !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_d got %08h want DEADBEEF", mem_d); end
        // A load right after shows no MERGE cycle was inserted.
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        $display("lw after sw: ready=%0b we=%0b rdata=%08h", req_ready, mem_we, rsp_rdata);
        checks++; if (req_ready !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL sw_nomerge got ready=%0b we=%0b want ready=1 we=0", req_ready, mem_we); end
        checks++; if (rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_readback got %08h want DEADBEEF", rsp_rdata); end
    endtask

    task automatic test_half_store_hi();
        drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h6, 32'h0000CAFE);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL sh_hi_c1_ready got %0b want 0", req_ready); end
        drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h6, 32'h0000CAFE);
        $display("sh hi merge: we=%0b a=%0d d=%08h", mem_we, mem_a, mem_d);
        checks++; if (mem_d !== 32'hCAFEBEEF || mem_a !== 11'd1) begin errors++; $display("FAIL sh_hi_d got a=%0d d=%08h want a=1 d=CAFEBEEF", mem_a, mem_d); end
        drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h6, 32'h0);
        checks++; if (rsp_rdata !== 32'hFFFFCAFE) begin errors++; $display("FAIL sh_hi_readback got %08h want FFFFCAFE", rsp_rdata); end
    endtask

    task automatic test_misalign();
`ifdef DMEM_MISALIGN_TRAP_EN
        drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h1, 32'h00001234);
        $display("sh addr1 trap: ready=%0b we=%0b mis=%0b", req_ready, mem_we, misalign);
        checks++; if (misalign !== 1'b1 || req_ready !== 1'b1) begin errors++; $display("FAIL mis_sh got mis=%0b ready=%0b want 1 1", misalign, req_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL mis_sh_we got %0b want 0", mem_we); end
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h2, 32'h0);
        $display("lw addr2 trap: mis=%0b rdata=%08h", misalign, rsp_rdata);
        checks++; if (misalign !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL mis_lw got mis=%0b rdata=%08h want 1 00000000", misalign, rsp_rdata); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL mis_lw_we got %0b want 0", mem_we); end
        w0_exp = 32'h5A99AABB;
`else
        drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h1, 32'h00001234);
        $display("sh addr1 c1: ready=%0b we=%0b mis=%0b", req_ready, mem_we, misalign);
        checks++; if (req_ready !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL mis_c1 got ready=%0b we=%0b want 0 0", req_ready, mem_we); end
        drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h1, 32'h00001234);
        $display("sh addr1 merge: we=%0b d=%08h mis=%0b", mem_we, mem_d, misalign);
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_flag got %0b want 0", misalign); end
        checks++; if (mem_we !== 1'b1 || mem_d !== 32'h5A991234) begin errors++; $display("FAIL mis_merge got we=%0b d=%08h want 1 5A991234", mem_we, mem_d); end
        w0_exp = 32'h5A991234;
`endif
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        checks++; if (sram[0] !== w0_exp) begin errors++; $display("FAIL mis_word0 got %08h want %08h", sram[0], w0_exp); end
    endtask

    task automatic test_reset_merge();
        drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h0, 32'h00000077);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rm_c1_ready got %0b want 0", req_ready); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        $display("reset in merge: we=%0b ready=%0b", mem_we, req_ready);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rm_we got %0b want 0", mem_we); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rm_ready got %0b want 0", req_ready); end
        @(negedge clk);
        reset = 1'b0;
        req_we = 1'b0; req_size = 2'b10;
        #1;
        $display("load after reset: ready=%0b rdata=%08h", req_ready, rsp_rdata);
        checks++; if (sram[0] !== w0_exp) begin errors++; $display("FAIL rm_sram got %08h want %08h", sram[0], w0_exp); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rm_load_ready got %0b want 1", req_ready); end
        checks++; if (rsp_rdata !== w0_exp) begin errors++; $display("FAIL rm_load_rdata got %08h want %08h", rsp_rdata, w0_exp); end
        drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0);
        checks++; if (rsp_rdata !== {24'h0, w0_exp[7:0]}) begin errors++; $display("FAIL rm_lbu got %08h want %08h", rsp_rdata, {24'h0, w0_exp[7:0]}); end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) sram[i] = 32'h0;
        sram[0] = 32'h8899AABB;
        w0_exp = 32'h8899AABB;
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(posedge clk);

        test_reset();
        test_idle();
        test_load();
        test_byte_store();
        test_word_store();
        test_half_store_hi();
        test_misalign();
        test_reset_merge();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Data-memory access unit between the pipelined CPU's MEM stage and the word-wide data SRAM (async read, synchronous word write). It converts byte/halfword/word loads and stores into word-granular SRAM accesses: loads are extracted and extended combinationally, and sub-word stores run a two-cycle registered read-modify-write. It drives a ready handshake that stalls the MEM stage while a merge is in flight.

## Interface
- ADDR_W, 11, SRAM word-index width; mem_a carries req_addr[ADDR_W+1:2].
- clk  in  1  CPU clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  MEM stage presents an access.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- req_unsigned  in  1  zero-extend sub-word loads (lbu/lhu).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- req_ready  out  1  access completes this cycle; MEM stalls while req_valid & !req_ready.
- rsp_rdata  out  32  load result, valid when req_valid & req_ready & !req_we.
- misalign  out  1  misaligned access flagged this cycle.
- mem_a  out  ADDR_W  SRAM word address.
- mem_d  out  32  SRAM write data.
- mem_we  out  1  SRAM write enable.
- mem_rdata  in  32  SRAM async read data at mem_a.

## Operation
- Lanes are little-endian. Byte lane = req_addr[1:0]; half lane = req_addr[1].
- FSM states: IDLE, MERGE. The FSM is in IDLE after reset.
- IDLE, load: req_ready=1. rsp_rdata = the selected lane, sign-extended unless req_unsigned. A word load returns mem_rdata unchanged. The FSM stays in IDLE.
- IDLE, word store: mem_we=1, mem_d=req_wdata, req_ready=1. The FSM stays in IDLE.
- IDLE, byte/half store: req_ready=0 and mem_we=0. The unit registers mem_rdata (old word), word address, lane, size and wdata, then moves to MERGE.
- MERGE: mem_a = registered address. mem_d = old word with the target lane replaced by wdata[7:0] or wdata[15:0]. mem_we=1, req_ready=1. The FSM returns to IDLE.
- In MERGE, only registered values are used. Changes on req_* during MERGE have no effect. The CPU holds the request stable; the bench asserts this.
- req_valid=0 in IDLE: mem_we=0, req_ready=0, rsp_rdata=0.
- Reset: state←IDLE and all registers←0. During the reset cycle: req_ready=0, mem_we=0, misalign=0, rsp_rdata=0. Reset during MERGE aborts the write, so the SRAM is unchanged.
- Back-to-back: a request presented in the cycle after MERGE is handled in IDLE with no extra bubble. A load immediately after a merge reads the updated word.

## Timing
- Load: 0 wait states; rsp_rdata is combinational from mem_rdata in the request cycle.
- Word store: 0 wait states; the SRAM is written at the end of the request cycle.
- Byte/half store: 1 wait state; the SRAM is written at the end of the MERGE cycle.
- The registered old word breaks the combinational path SRAM-read → merge → SRAM-write.
- misalign is combinational. It is valid only in the cycle in which req_ready=1.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined: a half access with addr[0]=1, or a word access with addr[1:0]≠0, completes in IDLE in one cycle with req_ready=1, misalign=1, mem_we=0, rsp_rdata=0. No MERGE is entered.
- DMEM_MISALIGN_TRAP_EN undefined: misalign is tied to 0. Low address bits below the access size are ignored: a half access uses addr[1], and a word access ignores addr[1:0].

## Structure
- Shared package cpu_mem_pkg holds the size encodings (SZ_B, SZ_H, SZ_W) and the FSM state enum.
- Sub-module dmem_lane_unit is purely combinational and contains the lane extract/extend logic and the lane merge logic. It is instantiated once and used by both the load path and the MERGE path.

## Test plan
- Preload word 0 with 0x8899AABB; signed byte load at addr 0x1 → req_ready=1 in the same cycle, rsp_rdata=0xFFFFFFAA.
- Same word; unsigned half load at addr 0x2 → rsp_rdata=0x00008899.
- Byte store of 0x5A at addr 0x3 → cycle 1: req_ready=0, mem_we=0; cycle 2: mem_we=1, mem_d=0x5A99AABB, req_ready=1. A following word load at 0x0 → 0x5A99AABB.
- Word store 0xDEADBEEF at addr 0x4 → mem_we=1, mem_a=1, req_ready=1 in the same cycle; the FSM never enters MERGE.
- Half store at addr 0x1 with the macro defined → misalign=1, mem_we never asserted, word 0 unchanged. Without the macro → misalign=0, the low half of word 0 is written after one wait state.
- Reset asserted in the MERGE cycle of a byte store → mem_we=0, SRAM unchanged, FSM in IDLE. The next load completes with 0 wait states.
